// File: rtl/alloc_mask16.sv
// alloc_mask16: 16-entry free-slot allocator that grants the k lowest free entries
// for a one-hot request count (k <= 4) and takes released entries back.
module alloc_mask16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic [4:0]  req_cnt,
    output logic        req_rdy,
    input  logic        free_vld,
    input  logic [15:0] free_mask,
    input  logic        flush,
    output logic        gnt_vld,
    output logic [15:0] gnt_mask,
    output logic [4:0]  gnt_cnt,
    output logic [16:0] free_cnt
);
    logic [15:0] free_vec_q, free_vec_d;
    logic        gnt_vld_q, gnt_vld_d;
    logic [15:0] gnt_mask_q, gnt_mask_d;
    logic [4:0]  gnt_cnt_q, gnt_cnt_d;
    logic [16:0] free_cnt_q, free_cnt_d;
    logic [4:0]  free_num, free_num_d;
    logic [4:0]  at_least;
    logic        req_onehot;
    logic [2:0]  req_num;
    logic [2:0]  taken;
    logic [15:0] sel_mask;
    logic        accept;

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    always_comb begin
        free_num = popcnt16(free_vec_q);
        for (int k = 0; k < 5; k++) at_least[k] = (free_num >= 5'(k));
        req_onehot = (req_cnt != 5'd0) && ((req_cnt & (req_cnt - 5'd1)) == 5'd0);
        req_num = req_cnt[4] ? 3'd4 : req_cnt[3] ? 3'd3 : req_cnt[2] ? 3'd2 :
                  req_cnt[1] ? 3'd1 : 3'd0;
        req_rdy = req_onehot && |(req_cnt & at_least) && !flush;
        accept = req_vld && req_rdy;
    end

    // Pick the req_num lowest-indexed free entries; nothing is taken without an accept.
    always_comb begin
        sel_mask = '0;
        taken = 3'd0;
        for (int i = 0; i < 16; i++) begin
            if (accept && free_vec_q[i] && taken < req_num) begin
                sel_mask[i] = 1'b1;
                taken = taken + 3'd1;
            end
        end
    end

    // A same-cycle release of a granted bit wins, so the bit ends free.
    always_comb begin
        free_vec_d = flush ? 16'hFFFF : ((free_vec_q & ~sel_mask) | (free_vld ? free_mask : 16'h0000));
        free_num_d = popcnt16(free_vec_d);
        free_cnt_d = 17'd1 << free_num_d;
        gnt_vld_d = accept;
        gnt_mask_d = sel_mask;
        gnt_cnt_d = accept ? req_cnt : 5'b00001;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_vec_q <= 16'hFFFF;
            gnt_vld_q <= 1'b0;
            gnt_mask_q <= 16'h0000;
            gnt_cnt_q <= 5'b00001;
            free_cnt_q <= 17'h10000;
        end else begin
            free_vec_q <= free_vec_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_mask_q <= gnt_mask_d;
            gnt_cnt_q <= gnt_cnt_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign gnt_vld = gnt_vld_q;
    assign gnt_mask = gnt_mask_q;
    assign gnt_cnt = gnt_cnt_q;
    assign free_cnt = free_cnt_q;
endmodule

// File: tb/tb_alloc_mask16.sv
// tb_alloc_mask16: directed scenarios plus randomized traffic checked against a
// free-list model of the allocator.
module tb_alloc_mask16;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_vld = 1'b0;
    logic [4:0]  req_cnt = 5'b00001;
    logic        req_rdy;
    logic        free_vld = 1'b0;
    logic [15:0] free_mask = 16'h0;
    logic        flush = 1'b0;
    logic        gnt_vld;
    logic [15:0] gnt_mask;
    logic [4:0]  gnt_cnt;
    logic [16:0] free_cnt;

    int checks = 0;
    int fails = 0;

    bit [15:0] m_free = 16'hFFFF;
    bit        m_gv = 1'b0;
    bit [15:0] m_gm = 16'h0;
    bit [4:0]  m_gc = 5'b00001;

    alloc_mask16 dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_cnt(req_cnt), .req_rdy(req_rdy),
        .free_vld(free_vld), .free_mask(free_mask), .flush(flush), .gnt_vld(gnt_vld),
        .gnt_mask(gnt_mask), .gnt_cnt(gnt_cnt), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ones(bit [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int req_k(bit [4:0] c);
        int k = -1;
        int n = 0;
        for (int i = 0; i < 5; i++) if (c[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    function automatic bit m_rdy(bit [4:0] c, bit fl);
        int k = req_k(c);
        return !fl && k >= 0 && ones(m_free) >= k;
    endfunction

    function automatic bit [16:0] m_fcnt();
        bit [16:0] r = 17'd0;
        r[ones(m_free)] = 1'b1;
        return r;
    endfunction

    task automatic drive(bit v, bit [4:0] c, bit fv, bit [15:0] fm, bit fl);
        req_vld = v; req_cnt = c; free_vld = fv; free_mask = fm; flush = fl;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        int q[$];
        int k;
        bit [15:0] sel = 16'h0;
        bit acc = req_vld && m_rdy(req_cnt, flush);
        if (acc) begin
            k = req_k(req_cnt);
            for (int i = 0; i < 16; i++) if (m_free[i]) q.push_back(i);
            for (int j = 0; j < k; j++) sel[q[j]] = 1'b1;
        end
        m_gv = acc;
        m_gm = sel;
        m_gc = acc ? req_cnt : 5'b00001;
        m_free = flush ? 16'hFFFF : ((m_free & ~sel) | (free_vld ? free_mask : 16'h0));
        @(posedge clk);
        #1;
    endtask

    task automatic set_free(bit [15:0] pat);
        drive(0, 5'b00001, 0, 16'h0, 1); tick();
        repeat (4) begin drive(1, 5'b10000, 0, 16'h0, 0); tick(); end
        drive(0, 5'b00001, 1, pat, 0); tick();
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 5'b00001, 0, 16'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt_vld !== 1'b0) begin fails++; $display("FAIL reset_gnt_vld got %b want 0", gnt_vld); end
        checks++; if (gnt_mask !== 16'h0) begin fails++; $display("FAIL reset_gnt_mask got %h want 0000", gnt_mask); end
        checks++; if (gnt_cnt !== 5'b00001) begin fails++; $display("FAIL reset_gnt_cnt got %b want 00001", gnt_cnt); end
        checks++; if (free_cnt !== 17'h10000) begin fails++; $display("FAIL reset_free_cnt got %h want 10000", free_cnt); end
        @(negedge clk);
        rst = 1'b1;
        m_free = 16'hFFFF; m_gv = 0; m_gm = 0; m_gc = 5'b00001;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        bit [15:0] em[4] = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
        bit [16:0] ef[4] = '{17'h01000, 17'h00100, 17'h00010, 17'h00001};
        drive(1, 5'b10000, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL fill_rdy[%0d] got %b want 1", i, req_rdy); end
            tick();
            checks++; if (gnt_vld !== 1'b1 || gnt_mask !== em[i]) begin fails++; $display("FAIL fill_gnt[%0d] got %b/%h want 1/%h", i, gnt_vld, gnt_mask, em[i]); end
            checks++; if (free_cnt !== ef[i]) begin fails++; $display("FAIL fill_free_cnt[%0d] got %h want %h", i, free_cnt, ef[i]); end
        end
        drive(0, 5'b00001, 0, 16'h0, 0);
        tick();
        checks++; if (gnt_vld !== 1'b0 || gnt_mask !== 16'h0 || gnt_cnt !== 5'b00001) begin fails++; $display("FAIL fill_idle got %b/%h/%b want 0/0000/00001", gnt_vld, gnt_mask, gnt_cnt); end
    endtask

    task automatic test_empty_release();
        drive(1, 5'b00010, 0, 16'h0, 0);
        checks++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL empty_rdy got %b want 0", req_rdy); end
        tick();
        checks++; if (gnt_vld !== 1'b0) begin fails++; $display("FAIL empty_gnt got %b want 0", gnt_vld); end
        drive(1, 5'b00010, 1, 16'h0100, 0);
        checks++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL release_same_rdy got %b want 0", req_rdy); end
        tick();
        drive(1, 5'b00010, 0, 16'h0, 0);
        checks++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL release_rdy got %b want 1", req_rdy); end
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_mask !== 16'h0100) begin fails++; $display("FAIL release_gnt got %b/%h want 1/0100", gnt_vld, gnt_mask); end
        drive(0, 5'b00001, 1, 16'hFFFF, 0);
        tick();
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    task automatic test_pattern();
        set_free(16'h8421);
        checks++; if (free_cnt !== 17'h00010) begin fails++; $display("FAIL pat_free_cnt got %h want 00010", free_cnt); end
        drive(1, 5'b01000, 0, 16'h0, 0);
        tick();
        checks++; if (gnt_mask !== 16'h0421 || gnt_cnt !== 5'b01000) begin fails++; $display("FAIL pat_gnt got %h/%b want 0421/01000", gnt_mask, gnt_cnt); end
        checks++; if (free_cnt !== 17'h00002) begin fails++; $display("FAIL pat_free_cnt_after got %h want 00002", free_cnt); end
    endtask

    task automatic test_alloc_free();
        set_free(16'h0001);
        drive(1, 5'b00010, 1, 16'h0002, 0);
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_mask !== 16'h0001) begin fails++; $display("FAIL af_gnt got %b/%h want 1/0001", gnt_vld, gnt_mask); end
        checks++; if (free_cnt !== 17'h00002) begin fails++; $display("FAIL af_free_cnt got %h want 00002", free_cnt); end
        drive(1, 5'b00010, 0, 16'h0, 0);
        tick();
        checks++; if (gnt_mask !== 16'h0002) begin fails++; $display("FAIL af_next_gnt got %h want 0002", gnt_mask); end
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    task automatic test_flush();
        set_free(16'h00F0);
        drive(1, 5'b00100, 1, 16'h0003, 1);
        checks++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL flush_rdy got %b want 0", req_rdy); end
        tick();
        checks++; if (gnt_vld !== 1'b0 || free_cnt !== 17'h10000) begin fails++; $display("FAIL flush_state got %b/%h want 0/10000", gnt_vld, free_cnt); end
        drive(1, 5'b00110, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL multi_hot_rdy[%0d] got %b want 0", i, req_rdy); end
            tick();
            checks++; if (gnt_vld !== 1'b0) begin fails++; $display("FAIL multi_hot_gnt[%0d] got %b want 0", i, gnt_vld); end
        end
        drive(1, 5'b00000, 0, 16'h0, 0);
        checks++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL zero_hot_rdy got %b want 0", req_rdy); end
        drive(1, 5'b00001, 0, 16'h0, 0);
        checks++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL zero_req_rdy got %b want 1", req_rdy); end
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_mask !== 16'h0 || gnt_cnt !== 5'b00001) begin fails++; $display("FAIL zero_req_gnt got %b/%h/%b want 1/0000/00001", gnt_vld, gnt_mask, gnt_cnt); end
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    task automatic test_random();
        bit [4:0] c;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 7) == 0) ? 5'($urandom) : (5'd1 << $urandom_range(0, 4));
            drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) == 0,
                  16'($urandom) & 16'($urandom), $urandom_range(0, 30) == 0);
            checks++; if (req_rdy !== m_rdy(req_cnt, flush)) begin fails++; $display("FAIL rnd_rdy[%0d] got %b want %b", n, req_rdy, m_rdy(req_cnt, flush)); end
            tick();
            checks++; if (gnt_vld !== m_gv || gnt_mask !== m_gm || gnt_cnt !== m_gc) begin fails++; $display("FAIL rnd_gnt[%0d] got %b/%h/%b want %b/%h/%b", n, gnt_vld, gnt_mask, gnt_cnt, m_gv, m_gm, m_gc); end
            checks++; if (free_cnt !== m_fcnt()) begin fails++; $display("FAIL rnd_free_cnt[%0d] got %h want %h", n, free_cnt, m_fcnt()); end
        end
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    task automatic test_reset_mid();
        set_free(16'hFFFF);
        drive(1, 5'b00100, 0, 16'h0, 0);
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_mask !== 16'h0003) begin fails++; $display("FAIL pre_reset_gnt got %b/%h want 1/0003", gnt_vld, gnt_mask); end
        rst = 1'b0;
        #1;
        checks++; if (gnt_vld !== 1'b0 || gnt_mask !== 16'h0 || gnt_cnt !== 5'b00001 || free_cnt !== 17'h10000) begin fails++; $display("FAIL async_reset got %b/%h/%b/%h want 0/0000/00001/10000", gnt_vld, gnt_mask, gnt_cnt, free_cnt); end
        @(negedge clk);
        rst = 1'b1;
        m_free = 16'hFFFF;
        drive(1, 5'b10000, 0, 16'h0, 0);
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_mask !== 16'h000F || free_cnt !== 17'h01000) begin fails++; $display("FAIL post_reset_gnt got %b/%h/%h want 1/000F/01000", gnt_vld, gnt_mask, free_cnt); end
        drive(0, 5'b00001, 0, 16'h0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_empty_release();
        test_pattern();
        test_alloc_free();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
